// File: rtl/keypad_scanner_if.sv
// Keypad-side signal bundle: row strobes out, column returns in, key events out.
interface keypad_scanner_if;
  logic [3:0] col;
  logic [3:0] row;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_down;

  // Scanner side drives rows and key events, reads columns.
  modport master (
    input  col,
    output row,
    output key_valid,
    output key_code,
    output key_down
  );

  // Keypad/consumer side drives columns, observes everything else.
  modport slave (
    output col,
    input  row,
    input  key_valid,
    input  key_code,
    input  key_down
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: strobes rows active-low, debounces full-matrix
// frames and emits a one-cycle event for each clean single-key press.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV        = 100000,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input logic             clk,
  input logic             rst,
  keypad_scanner_if.master kp
);

  localparam int unsigned DivW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(SCAN_DIV - 1);
  localparam logic [3:0]  CntMax = 4'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {StIdle, StHeld, StBlocked} state_e;

  logic [3:0]      col_meta_q, col_s_q;
  logic [DivW-1:0] div_q, div_d;
  logic [1:0]      row_idx_q, row_idx_d;
  logic [15:0]     frame_q, frame_d;
  logic [15:0]     prev_q, prev_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [15:0]     stable_q, stable_d;
  logic            key_down_q;
  state_e          state_q, state_d;
  logic            key_valid_q, key_valid_d;
  logic [3:0]      key_code_q, key_code_d;

  logic            scan_tick;
  logic [15:0]     frame_full;
  logic            single_key;
  logic [3:0]      key_idx;
  logic [15:0]     held_map;

  assign scan_tick = (div_q == DivMax);

  assign kp.row       = ~(4'b0001 << row_idx_q);
  assign kp.key_valid = key_valid_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_down  = key_down_q;

  // Two-flop synchroniser for the asynchronous column returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta_q <= 4'hF;
      col_s_q    <= 4'hF;
    end else begin
      col_meta_q <= kp.col;
      col_s_q    <= col_meta_q;
    end
  end

  // Row divider, frame capture and frame-to-frame debounce.
  always_comb begin
    div_d      = div_q + DivW'(1);
    row_idx_d  = row_idx_q;
    frame_d    = frame_q;
    prev_d     = prev_q;
    cnt_d      = cnt_q;
    stable_d   = stable_q;
    // Frame as it will look once the current row's sample lands this edge.
    frame_full = frame_q;
    frame_full[row_idx_q*4 +: 4] = ~col_s_q;
    if (scan_tick) begin
      div_d     = '0;
      frame_d   = frame_full;
      row_idx_d = row_idx_q + 2'd1;
      if (row_idx_q == 2'd3) begin
        if (frame_full == prev_q) begin
          cnt_d = (cnt_q < CntMax) ? cnt_q + 4'd1 : cnt_q;
        end else begin
          cnt_d = 4'd0;
        end
        prev_d = frame_full;
        if (cnt_d == CntMax) begin
          stable_d = frame_full;
        end
      end
    end
  end

  // Scan and debounce state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q      <= '0;
      row_idx_q  <= 2'd0;
      frame_q    <= '0;
      prev_q     <= '0;
      cnt_q      <= 4'd0;
      stable_q   <= '0;
      key_down_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      row_idx_q  <= row_idx_d;
      frame_q    <= frame_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      stable_q   <= stable_d;
      key_down_q <= (stable_q != 16'd0);
    end
  end

  // Decode whether the stable map holds exactly one key, and which one.
  always_comb begin
    single_key = 1'b0;
    key_idx    = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (stable_q == (16'd1 << i)) begin
        single_key = 1'b1;
        key_idx    = 4'(i);
      end
    end
  end

  assign held_map = 16'd1 << key_code_q;

  // Press FSM: report a lone key once; any rollover blocks until full release.
  always_comb begin
    state_d     = state_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    unique case (state_q)
      StIdle: begin
        if (single_key) begin
          key_code_d  = key_idx;
          key_valid_d = 1'b1;
          state_d     = StHeld;
        end else if (stable_q != 16'd0) begin
          state_d = StBlocked;
        end
      end
      StHeld: begin
        if (stable_q == 16'd0) begin
          state_d = StIdle;
        end else if (stable_q != held_map) begin
          state_d = StBlocked;
        end
      end
      StBlocked: begin
        if (stable_q == 16'd0) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM and event output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
    end
  end

endmodule
